csr_commit_ctrl: RTL and testbench
==================================

// Module: csr_commit_ctrl
// PURPOSE
//  Sequences every access to the machine-mode CSR file (mepc/mcause/mstatus/mtvec, RO mvendorid/marchid) at commit.
//  Takes one CSR/ECALL/MRET op from the ROB head, does read-modify-write, drives the CSR file's csrd/csr_wen/ecall_flag.
//  Issues the front-end redirect + pipeline flush for traps and MRET; returns rd data to the ROB.
//  One op in flight at a time; ROB holds further CSR ops until req_ready.
// PARAMETERS
//  ROB_W          5     width of ROB tag carried through
//  DRAIN_TIMEOUT  255   max DRAIN cycles before drain_err (8-bit counter)
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  req_valid      in   1      ROB head holds a CSR-class op
//  req_ready      out  1      ctrl accepts op (IDLE only)
//  req_op         in   3      0 CSRRW,1 CSRRS,2 CSRRC,3 ECALL,4 MRET, 5-7 illegal
//  req_addr       in   12     CSR address
//  req_src        in   32     rs1 value / zimm
//  req_src_zero   in   1      rs1==x0 (suppresses write for RS/RC)
//  req_pc         in   32     pc of op
//  req_rob_id     in   ROB_W  tag
//  sb_empty       in   1      store buffer drained
//  mepc_in,mcause_in,mstatus_in,mtvec_in,mvendorid_in,marchid_in  in 32 each  CSR file outputs
//  csrd           out  32     write data to CSR file
//  csr_wen        out  4      one-hot: [0]mepc [1]mcause [2]mstatus [3]mtvec
//  ecall_flag     out  1      CSR file loads mepc<=ecall_pc, mcause<=11
//  ecall_pc       out  32     pc for mepc on trap
//  redirect_valid out  1      1-cycle pulse; front end fetches redirect_pc
//  redirect_pc    out  32
//  flush          out  1      1-cycle pulse, same cycle as redirect_valid
//  resp_valid     out  1      result for ROB
//  resp_ready     in   1
//  resp_data      out  32     old CSR value (0 for ECALL/MRET/illegal)
//  resp_rob_id    out  ROB_W
//  resp_illegal   out  1      illegal op/address/RO write
//  drain_err      out  1      sticky; set on DRAIN timeout, cleared by reset
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 next cycle; all other outputs 0, counter 0, drain_err 0.
//  States: IDLE, EXEC, WRITE, DRAIN, TRAP, REDIR, RESP.
//  IDLE: req_ready=1; req_valid&req_ready captures op/addr/src/pc/tag. CSR ops->EXEC; ECALL/MRET->DRAIN.
//   illegal op->RESP with resp_illegal=1.
//  EXEC (1 cycle): decode addr 0x341 mepc,0x342 mcause,0x300 mstatus,0x305 mtvec,0xF11 mvendorid,0xF12 marchid.
//   Latch old=selected CSR.
//   new = RW:src | RS:old|src | RC:old&~src.
//   wr = RW | ~req_src_zero.
//   Unknown addr, or wr to 0xF11/0xF12 -> illegal, no write, ->RESP. Else wr->WRITE, !wr->RESP.
//  WRITE (1 cycle): csrd=new, csr_wen one-hot for addr; ->RESP. csr_wen==0 in every other state.
//  DRAIN: wait sb_empty; counter increments each cycle.
//   At counter==DRAIN_TIMEOUT: set drain_err, keep waiting; no abort.
//   ECALL->TRAP on sb_empty; MRET->REDIR on sb_empty. Counter clears on exit.
//  TRAP (1 cycle): ecall_flag=1, ecall_pc=captured pc, csrd=0, csr_wen=0; ->REDIR.
//  REDIR (1 cycle): redirect_valid=flush=1.
//   redirect_pc = mtvec_in&~3 (ECALL; mtvec_in sampled this cycle, direct mode only) or mepc_in (MRET); ->RESP.
//  RESP: resp_valid held with stable data/tag until resp_ready; on handshake ->IDLE, req_ready=1 the next cycle.
//  Latency, req handshake at cycle 0, resp_ready tied 1:
//   CSRRW resp_valid cycle 3.
//   RS/RC with src_zero cycle 2.
//   ECALL with sb_empty=1: ecall_flag cycle 2, redirect cycle 3, resp cycle 4.
//   MRET: redirect cycle 2, resp cycle 3.
//  resp_data is always the pre-write value; a simultaneous CSR-file ecall write cannot occur (ctrl is the only writer).
//  Reset in any state returns to IDLE next cycle; pending write/redirect is dropped, no pulse emitted.
//  mstatus MIE/MPIE update on trap/MRET is NOT done here.
// TESTING
//  1. Reset, CSRRW 0x305 src=0x8000_0100 -> csr_wen=4'b1000, csrd=0x8000_0100 at cycle 2; resp_data=old mtvec at cycle 3.
//  2. mstatus=0x1800: CSRRS 0x300 src=0x8 -> csrd=0x1808; CSRRC src=0x800 -> csrd=0x1008.
//     CSRRS src_zero=1 -> no wen, resp_data=0x1800.
//  3. ECALL pc=0x8000_0040, mtvec=0x8000_0101, sb_empty low 5 cycles -> ecall_flag once, ecall_pc=0x8000_0040;
//     redirect_pc=0x8000_0100 with flush; resp after.
//  4. MRET with mepc=0x8000_0044 -> redirect_pc=0x8000_0044, no csr_wen, no ecall_flag.
//  5. CSRRW 0xF11; op=6; addr 0x7C0 -> resp_illegal=1, csr_wen stays 0; CSRRS 0xF12 src_zero=1 -> legal, data 0x016FBCBD.
//  6. resp_ready low 4 cycles: resp held stable, req_ready=0. sb_empty low 256 cycles: drain_err=1.
//     Reset asserted in WRITE/DRAIN: no wen/redirect, IDLE next cycle.

Source files
------------

// File: rtl/csr_commit_ctrl.sv
// Commit-time sequencer for the machine-mode CSR file: CSR read-modify-write,
// ECALL trap entry and MRET return, one operation in flight at a time.
module csr_commit_ctrl #(
  parameter int ROB_W         = 5,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [11:0]      req_addr,
  input  logic [31:0]      req_src,
  input  logic             req_src_zero,
  input  logic [31:0]      req_pc,
  input  logic [ROB_W-1:0] req_rob_id,
  input  logic             sb_empty,
  input  logic [31:0]      mepc_in,
  input  logic [31:0]      mcause_in,
  input  logic [31:0]      mstatus_in,
  input  logic [31:0]      mtvec_in,
  input  logic [31:0]      mvendorid_in,
  input  logic [31:0]      marchid_in,
  output logic [31:0]      csrd,
  output logic [3:0]       csr_wen,
  output logic             ecall_flag,
  output logic [31:0]      ecall_pc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [ROB_W-1:0] resp_rob_id,
  output logic             resp_illegal,
  output logic             drain_err
);

  localparam int          DATA_W      = 32;
  localparam logic [7:0]  DRAIN_LIMIT = 8'(DRAIN_TIMEOUT);

  localparam logic [2:0]  OP_RW   = 3'd0;
  localparam logic [2:0]  OP_RS   = 3'd1;
  localparam logic [2:0]  OP_RC   = 3'd2;
  localparam logic [2:0]  OP_ECALL = 3'd3;
  localparam logic [2:0]  OP_MRET = 3'd4;

  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DRAIN,
    S_TRAP,
    S_REDIR,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Saturating so a very long drain never wraps back below the limit.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Capture stage: op fields held from the accept cycle until the response.
  logic [2:0]        op_p0;
  logic [11:0]       addr_p0;
  logic [DATA_W-1:0] src_p0;
  logic              src_zero_p0;
  logic [DATA_W-1:0] pc_p0;
  logic [ROB_W-1:0]  rob_p0;

  // Execute stage results: pre-write value, merged value, write strobe.
  logic [DATA_W-1:0] old_p1;
  logic [DATA_W-1:0] new_p1;
  logic [3:0]        wen_p1;
  logic              illegal_p1;

  logic [7:0]        drain_cnt;
  logic              drain_err_q;

  logic              dec_known;
  logic              dec_ro;
  logic [3:0]        dec_wen;
  logic [DATA_W-1:0] dec_old;
  logic              wr_en;
  logic [DATA_W-1:0] new_val;
  logic              exec_illegal;

  always_comb begin
    dec_known = 1'b1;
    dec_ro    = 1'b0;
    dec_wen   = 4'b0000;
    dec_old   = '0;
    case (addr_p0)
      A_MEPC:      begin dec_old = mepc_in;      dec_wen = 4'b0001; end
      A_MCAUSE:    begin dec_old = mcause_in;    dec_wen = 4'b0010; end
      A_MSTATUS:   begin dec_old = mstatus_in;   dec_wen = 4'b0100; end
      A_MTVEC:     begin dec_old = mtvec_in;     dec_wen = 4'b1000; end
      A_MVENDORID: begin dec_old = mvendorid_in; dec_ro  = 1'b1;    end
      A_MARCHID:   begin dec_old = marchid_in;   dec_ro  = 1'b1;    end
      default:     dec_known = 1'b0;
    endcase

    wr_en = (op_p0 == OP_RW) || !src_zero_p0;

    case (op_p0)
      OP_RW:   new_val = src_p0;
      OP_RS:   new_val = dec_old | src_p0;
      default: new_val = dec_old & ~src_p0;
    endcase

    exec_illegal = !dec_known || (dec_ro && wr_en);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == OP_RW || req_op == OP_RS || req_op == OP_RC)
            state_d = S_EXEC;
          else if (req_op == OP_ECALL || req_op == OP_MRET)
            state_d = S_DRAIN;
          else
            state_d = S_RESP;
        end
      end
      S_EXEC:  state_d = (exec_illegal || !wr_en) ? S_RESP : S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_DRAIN: begin
        if (sb_empty)
          state_d = (op_p0 == OP_ECALL) ? S_TRAP : S_REDIR;
      end
      S_TRAP:  state_d = S_REDIR;
      S_REDIR: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt   <= 8'd0;
      drain_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DRAIN && !sb_empty)
        drain_cnt <= sat_inc(drain_cnt);
      else
        drain_cnt <= 8'd0;
      if (state_q == S_DRAIN && drain_cnt == DRAIN_LIMIT)
        drain_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && req_valid) begin
      op_p0       <= req_op;
      addr_p0     <= req_addr;
      src_p0      <= req_src;
      src_zero_p0 <= req_src_zero;
      pc_p0       <= req_pc;
      rob_p0      <= req_rob_id;
      old_p1      <= '0;
      wen_p1      <= 4'b0000;
      illegal_p1  <= (req_op > OP_MRET);
    end else if (state_q == S_EXEC) begin
      old_p1     <= exec_illegal ? '0 : dec_old;
      new_p1     <= new_val;
      wen_p1     <= dec_wen;
      illegal_p1 <= exec_illegal;
    end
  end

  // Side-effect strobes are masked by reset so a write or redirect that is
  // pending in the reset cycle never reaches the CSR file or front end.
  always_comb begin
    req_ready      = (state_q == S_IDLE);
    csr_wen        = (state_q == S_WRITE && !reset) ? wen_p1 : 4'b0000;
    csrd           = (state_q == S_WRITE) ? new_p1 : '0;
    ecall_flag     = (state_q == S_TRAP) && !reset;
    ecall_pc       = (state_q == S_TRAP) ? pc_p0 : '0;
    redirect_valid = (state_q == S_REDIR) && !reset;
    flush          = (state_q == S_REDIR) && !reset;
    redirect_pc    = '0;
    if (state_q == S_REDIR)
      redirect_pc = (op_p0 == OP_ECALL) ? (mtvec_in & ~32'h3) : mepc_in;
    resp_valid     = (state_q == S_RESP);
    resp_data      = (state_q == S_RESP) ? old_p1 : '0;
    resp_rob_id    = (state_q == S_RESP) ? rob_p0 : '0;
    resp_illegal   = (state_q == S_RESP) && illegal_p1;
    drain_err      = drain_err_q;
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed vector table, multi-cycle corner
// sequences and randomized ops scored against a CSR-file reference model.
module tb_csr_commit_ctrl;
  localparam int ROB_W  = 5;
  localparam int BUDGET = 40;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [11:0]      req_addr;
  logic [31:0]      req_src;
  logic             req_src_zero;
  logic [31:0]      req_pc;
  logic [ROB_W-1:0] req_rob_id;
  logic             sb_empty;
  logic [31:0]      mepc_in, mcause_in, mstatus_in, mtvec_in, mvendorid_in, marchid_in;
  logic [31:0]      csrd;
  logic [3:0]       csr_wen;
  logic             ecall_flag;
  logic [31:0]      ecall_pc;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [ROB_W-1:0] resp_rob_id;
  logic             resp_illegal;
  logic             drain_err;

  csr_commit_ctrl #(.ROB_W(ROB_W), .DRAIN_TIMEOUT(255)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
    .req_pc(req_pc), .req_rob_id(req_rob_id), .sb_empty(sb_empty),
    .mepc_in(mepc_in), .mcause_in(mcause_in), .mstatus_in(mstatus_in),
    .mtvec_in(mtvec_in), .mvendorid_in(mvendorid_in), .marchid_in(marchid_in),
    .csrd(csrd), .csr_wen(csr_wen), .ecall_flag(ecall_flag), .ecall_pc(ecall_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rob_id(resp_rob_id), .resp_illegal(resp_illegal), .drain_err(drain_err)
  );

  always #5 clock = ~clock;

  // CSR file the controller writes: index 0 mepc,1 mcause,2 mstatus,3 mtvec,4 mvendorid,5 marchid
  logic [31:0] fcsr [6] = '{32'h8000_0044, 32'h0, 32'h1800, 32'h8000_0101, 32'h0000_0602, 32'h016F_BCBD};
  assign mepc_in      = fcsr[0];
  assign mcause_in    = fcsr[1];
  assign mstatus_in   = fcsr[2];
  assign mtvec_in     = fcsr[3];
  assign mvendorid_in = fcsr[4];
  assign marchid_in   = fcsr[5];

  always @(posedge clock) begin
    if (csr_wen[0]) fcsr[0] <= csrd;
    if (csr_wen[1]) fcsr[1] <= csrd;
    if (csr_wen[2]) fcsr[2] <= csrd;
    if (csr_wen[3]) fcsr[3] <= csrd;
    if (ecall_flag) begin
      fcsr[0] <= ecall_pc;
      fcsr[1] <= 32'd11;
    end
  end

  // Reference model state: architectural CSR values as the ISA rules say they should be.
  logic [31:0] sh [6] = '{32'h8000_0044, 32'h0, 32'h1800, 32'h8000_0101, 32'h0000_0602, 32'h016F_BCBD};
  logic [11:0] csr_addr [6] = '{12'h341, 12'h342, 12'h300, 12'h305, 12'hF11, 12'hF12};

  typedef struct {
    logic [3:0]  wen;  logic [31:0] csrd; int t_wen;
    bit          ecall; logic [31:0] epc; int t_ecall;
    bit          redir; logic [31:0] rpc; int t_redir;
    logic [31:0] data; bit ill; int lat;
  } exp_t;

  typedef struct {
    int wen_cnt; logic [3:0] wen; logic [31:0] csrd; int t_wen;
    int ecall_cnt; logic [31:0] epc; int t_ecall;
    int redir_cnt; int flush_cnt; logic [31:0] rpc; int t_redir;
    int t_resp; logic [31:0] data; bit ill; logic [ROB_W-1:0] rob;
  } obs_t;

  typedef struct {
    logic [2:0] op; logic [11:0] addr; logic [31:0] src; logic zero; logic [31:0] pc;
    logic [3:0] wen; logic [31:0] csrd; bit ecall; bit redir; logic [31:0] rpc;
    logic [31:0] data; bit ill; int lat;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] src, input logic zero,
                                 input logic [31:0] pc, input int d);
    exp_t e;
    int idx;
    bit writes;
    logic [31:0] old, nv;
    e = '{default: 0};
    if (op > 3'd4) begin
      e.ill = 1; e.lat = 1;
      return e;
    end
    if (op == 3'd3) begin
      e.ecall = 1; e.epc = pc; e.t_ecall = d + 1;
      e.redir = 1; e.rpc = sh[3] & 32'hFFFF_FFFC; e.t_redir = d + 2;
      e.lat = d + 3;
      sh[0] = pc; sh[1] = 32'd11;
      return e;
    end
    if (op == 3'd4) begin
      e.redir = 1; e.rpc = sh[0]; e.t_redir = d + 1; e.lat = d + 2;
      return e;
    end
    idx = -1;
    for (int i = 0; i < 6; i++) if (addr == csr_addr[i]) idx = i;
    writes = (op == 3'd0) || !zero;
    e.lat = 2;
    if (idx < 0 || (idx >= 4 && writes)) begin
      e.ill = 1;
      return e;
    end
    old = sh[idx];
    e.data = old;
    if (writes) begin
      nv = (op == 3'd0) ? src : (op == 3'd1) ? (old | src) : (old & ~src);
      e.wen = 4'(1 << idx); e.csrd = nv; e.t_wen = 2; e.lat = 3;
      sh[idx] = nv;
    end
    return e;
  endfunction

  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic zero, input logic [31:0] pc, input logic [ROB_W-1:0] rob,
                         input int d, output obs_t o);
    int w;
    o = '{default: 0};
    o.t_resp = -1;
    @(posedge clock); #1;
    sb_empty = (d <= 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src;
    req_src_zero = zero; req_pc = pc; req_rob_id = rob;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clock);
      if (csr_wen != 4'b0) begin o.wen_cnt++; o.wen = csr_wen; o.csrd = csrd; o.t_wen = c; end
      if (ecall_flag) begin o.ecall_cnt++; o.epc = ecall_pc; o.t_ecall = c; end
      if (redirect_valid) begin o.redir_cnt++; o.rpc = redirect_pc; o.t_redir = c; end
      if (flush) o.flush_cnt++;
      if (resp_valid) begin
        o.t_resp = c; o.data = resp_data; o.ill = resp_illegal; o.rob = resp_rob_id;
        break;
      end
      if (c == d) sb_empty = 1'b1;
    end
    sb_empty = 1'b1;
  endtask

  task automatic compare(input string tag, input obs_t o, input exp_t e, input logic [ROB_W-1:0] rob);
    check($sformatf("%s.latency", tag), 32'(o.t_resp), 32'(e.lat));
    check($sformatf("%s.wen_pulses", tag), 32'(o.wen_cnt), 32'(e.wen != 4'b0));
    if (e.wen != 4'b0) begin
      check($sformatf("%s.csr_wen", tag), 32'(o.wen), 32'(e.wen));
      check($sformatf("%s.csrd", tag), o.csrd, e.csrd);
      check($sformatf("%s.wen_cycle", tag), 32'(o.t_wen), 32'(e.t_wen));
    end
    check($sformatf("%s.ecall_pulses", tag), 32'(o.ecall_cnt), 32'(e.ecall));
    if (e.ecall) begin
      check($sformatf("%s.ecall_pc", tag), o.epc, e.epc);
      check($sformatf("%s.ecall_cycle", tag), 32'(o.t_ecall), 32'(e.t_ecall));
    end
    check($sformatf("%s.redirect_pulses", tag), 32'(o.redir_cnt), 32'(e.redir));
    check($sformatf("%s.flush_pulses", tag), 32'(o.flush_cnt), 32'(e.redir));
    if (e.redir) begin
      check($sformatf("%s.redirect_pc", tag), o.rpc, e.rpc);
      check($sformatf("%s.redirect_cycle", tag), 32'(o.t_redir), 32'(e.t_redir));
    end
    check($sformatf("%s.resp_data", tag), o.data, e.data);
    check($sformatf("%s.resp_illegal", tag), 32'(o.ill), 32'(e.ill));
    check($sformatf("%s.resp_rob_id", tag), 32'(o.rob), 32'(rob));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    exp_t e, dummy;
    obs_t o;
    int cnt_r, cnt_e, cnt_v, w;
    logic [2:0] op;
    logic [11:0] addr;
    logic [ROB_W-1:0] rob;
    int r, d;

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
    req_src_zero = 1'b0; req_pc = '0; req_rob_id = '0; sb_empty = 1'b1; resp_ready = 1'b1;

    tbl[0]  = '{3'd3, 12'h000, 32'h0,         1'b0, 32'h8000_0040, 4'h0, 32'h0,         1, 1, 32'h8000_0100, 32'h0,         0, 4};
    tbl[1]  = '{3'd4, 12'h000, 32'h0,         1'b0, 32'h8000_0050, 4'h0, 32'h0,         0, 1, 32'h8000_0040, 32'h0,         0, 3};
    tbl[2]  = '{3'd0, 12'h341, 32'h8000_0044, 1'b0, 32'h0000_0102, 4'h1, 32'h8000_0044, 0, 0, 32'h0,         32'h8000_0040, 0, 3};
    tbl[3]  = '{3'd4, 12'h000, 32'h0,         1'b0, 32'h0000_0103, 4'h0, 32'h0,         0, 1, 32'h8000_0044, 32'h0,         0, 3};
    tbl[4]  = '{3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0000_0104, 4'h8, 32'h8000_0100, 0, 0, 32'h0,         32'h8000_0101, 0, 3};
    tbl[5]  = '{3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h0000_0105, 4'h4, 32'h0000_1808, 0, 0, 32'h0,         32'h0000_1800, 0, 3};
    tbl[6]  = '{3'd2, 12'h300, 32'h0000_0800, 1'b0, 32'h0000_0106, 4'h4, 32'h0000_1008, 0, 0, 32'h0,         32'h0000_1808, 0, 3};
    tbl[7]  = '{3'd1, 12'h300, 32'h0000_FFFF, 1'b1, 32'h0000_0107, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0000_1008, 0, 2};
    tbl[8]  = '{3'd0, 12'hF11, 32'h0000_0005, 1'b0, 32'h0000_0108, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 2};
    tbl[9]  = '{3'd6, 12'h300, 32'h0000_0005, 1'b0, 32'h0000_0109, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 1};
    tbl[10] = '{3'd1, 12'h7C0, 32'h0000_0001, 1'b0, 32'h0000_010A, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         1, 2};
    tbl[11] = '{3'd1, 12'hF12, 32'h0000_0000, 1'b1, 32'h0000_010B, 4'h0, 32'h0,         0, 0, 32'h0,         32'h016F_BCBD, 0, 2};
    tbl[12] = '{3'd2, 12'h342, 32'h0000_000F, 1'b0, 32'h0000_010C, 4'h2, 32'h0,         0, 0, 32'h0,         32'h0000_000B, 0, 3};
    tbl[13] = '{3'd1, 12'hF11, 32'h0000_0000, 1'b1, 32'h0000_010D, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0000_0602, 0, 2};

    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.csr_wen", 32'(csr_wen), 32'd0);
    check("reset.csrd", csrd, 32'd0);
    check("reset.ecall_flag", 32'(ecall_flag), 32'd0);
    check("reset.redirect_valid", 32'(redirect_valid), 32'd0);
    check("reset.flush", 32'(flush), 32'd0);
    check("reset.resp_valid", 32'(resp_valid), 32'd0);
    check("reset.resp_data", resp_data, 32'd0);
    check("reset.drain_err", 32'(drain_err), 32'd0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      e = '{default: 0};
      e.wen = tbl[i].wen; e.csrd = tbl[i].csrd; e.t_wen = 2;
      e.ecall = tbl[i].ecall; e.epc = tbl[i].pc; e.t_ecall = 2;
      e.redir = tbl[i].redir; e.rpc = tbl[i].rpc; e.t_redir = tbl[i].ecall ? 3 : 2;
      e.data = tbl[i].data; e.ill = tbl[i].ill; e.lat = tbl[i].lat;
      dummy = model(tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].zero, tbl[i].pc, 1);
      rob = 5'(i + 1);
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].zero, tbl[i].pc, rob, 1, o);
      compare($sformatf("vec%0d", i), o, e, rob);
    end

    // Response back-pressure: held stable, no new request accepted
    @(posedge clock); #1;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd1; req_addr = 12'hF12; req_src = 32'h0;
    req_src_zero = 1'b1; req_rob_id = 5'd7;
    @(posedge clock); #1;
    req_valid = 1'b0;
    w = 0;
    @(negedge clock);
    while (!resp_valid && w < 10) begin @(negedge clock); w++; end
    check("hold.resp_seen", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); @(negedge clock);
      check($sformatf("hold%0d.resp_valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("hold%0d.resp_data", k), resp_data, 32'h016F_BCBD);
      check($sformatf("hold%0d.resp_rob_id", k), 32'(resp_rob_id), 32'd7);
      check($sformatf("hold%0d.req_ready", k), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    check("hold.after_resp_valid", 32'(resp_valid), 32'd0);
    check("hold.after_req_ready", 32'(req_ready), 32'd1);

    // Drain timeout: store buffer stuck, drain_err sets exactly after the limit
    @(posedge clock); #1;
    sb_empty = 1'b0;
    req_valid = 1'b1; req_op = 3'd4; req_rob_id = 5'd3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    cnt_r = 0;
    for (int c = 1; c <= 258; c++) begin
      @(negedge clock);
      if (redirect_valid || resp_valid) cnt_r++;
      if (c == 256) check("drain.err_before_limit", 32'(drain_err), 32'd0);
      if (c == 257) check("drain.err_at_limit", 32'(drain_err), 32'd1);
    end
    check("drain.no_early_redirect", 32'(cnt_r), 32'd0);
    sb_empty = 1'b1;
    cnt_r = 0;
    w = 0;
    while (!resp_valid && w < 10) begin
      @(negedge clock);
      if (redirect_valid) begin
        cnt_r++;
        check("drain.redirect_pc", redirect_pc, 32'h8000_0044);
      end
      w++;
    end
    check("drain.redirect_pulses", 32'(cnt_r), 32'd1);
    check("drain.resp_seen", 32'(resp_valid), 32'd1);
    @(negedge clock);
    check("drain.err_sticky", 32'(drain_err), 32'd1);
    do_reset();
    @(negedge clock);
    check("drain.err_cleared", 32'(drain_err), 32'd0);

    // Reset while in WRITE: the pending write is dropped
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h341; req_src = 32'hDEAD_BEEF;
    req_src_zero = 1'b0; req_rob_id = 5'd9;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_write.csr_wen", 32'(csr_wen), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_write.req_ready", 32'(req_ready), 32'd1);
    check("rst_write.mepc_kept", mepc_in, 32'h8000_0044);

    // Reset while in DRAIN: no trap, redirect or response afterwards
    @(posedge clock); #1;
    sb_empty = 1'b0;
    req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h9000_0000;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sb_empty = 1'b1;
    cnt_e = 0; cnt_r = 0; cnt_v = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (ecall_flag) cnt_e++;
      if (redirect_valid || flush) cnt_r++;
      if (resp_valid || !req_ready) cnt_v++;
    end
    check("rst_drain.ecall_pulses", 32'(cnt_e), 32'd0);
    check("rst_drain.redirect_pulses", 32'(cnt_r), 32'd0);
    check("rst_drain.idle", 32'(cnt_v), 32'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       op = 3'(r % 3);
      else if (r == 6) op = 3'd3;
      else if (r == 7) op = 3'd4;
      else             op = 3'($urandom_range(5, 7));
      r = $urandom_range(0, 6);
      addr = (r < 6) ? csr_addr[r] : 12'($urandom);
      req_src = $urandom;
      d = $urandom_range(1, 4);
      rob = 5'($urandom);
      begin
        logic [31:0] src_v, pc_v;
        logic zero_v;
        src_v = $urandom;
        pc_v = $urandom & 32'hFFFF_FFFC;
        zero_v = ($urandom_range(0, 3) == 0);
        e = model(op, addr, src_v, zero_v, pc_v, d);
        run_txn(op, addr, src_v, zero_v, pc_v, rob, d, o);
        compare($sformatf("rand%0d", n), o, e, rob);
      end
    end

    @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
